memory_bist: RTL and testbench

MEMORY_BIST -- requirements
Module: memory_bist

---
 rtl/memory_pkg.sv | 24 ++
 rtl/memory_array.sv | 61 ++++++
 rtl/memory_bist.sv | 169 ++++++++++++++++
 tb/tb_memory_bist.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared BIST state encoding, march pattern constants and the parity build option.
// Build option: define MEMORY_PARITY_EN to store an even-parity bit with every word.
package memory_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WRITE,
        READ,
        CHECK,
        DONE
    } bist_state_e;

    // Sliced down to DATA_WIDTH by the users (DATA_WIDTH up to 64).
    localparam logic [63:0] PAT_ZEROS = '0;
    localparam logic [63:0] PAT_ONES  = '1;

`ifdef MEMORY_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/memory_array.sv
// Single-port word storage with registered read-first output and optional parity.
// Build option: MEMORY_PARITY_EN adds a stored even-parity bit and a read-side check.
module memory_array
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  parity_err
);

    localparam int SW = DATA_WIDTH + PARITY_BITS;

    logic [SW-1:0] mem_q [RAM_DEPTH];
    logic [SW-1:0] rword_q;
    logic [SW-1:0] rword_d;
    logic [SW-1:0] wword;
    logic          in_range;

`ifdef MEMORY_PARITY_EN
    assign wword      = {^wdata, wdata};
    assign parity_err = ^rword_q;
`else
    assign wword      = wdata;
    assign parity_err = 1'b0;
`endif

    assign rdata = rword_q[DATA_WIDTH-1:0];

    always_comb begin
        in_range = (32'(addr) < RAM_DEPTH);
        rword_d  = rword_q;
        if (re) begin
            rword_d = in_range ? mem_q[addr] : '0;
        end
    end

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem_q[addr] <= wword;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rword_q <= '0;
        end else begin
            rword_q <= rword_d;
        end
    end

endmodule

// File: rtl/memory_bist.sv
// Memory with a march-style built-in self test sharing the single array port.
// Build option: MEMORY_PARITY_EN enables parity storage, parity_err and parity failures in CHECK.
module memory_bist
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_input,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_output,
    output logic                  read_valid,
    output logic                  parity_err,
    input  logic                  bist_start,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic                  bist_pass,
    output logic [ADDR_WIDTH-1:0] bist_fail_addr,
    output logic [ADDR_WIDTH:0]   bist_err_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    bist_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
    logic [ADDR_WIDTH:0]   err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  read_valid_q, read_valid_d;

    logic                  arr_we, arr_re, arr_perr;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;

    memory_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .we        (arr_we),
        .re        (arr_re),
        .addr      (arr_addr),
        .wdata     (arr_wdata),
        .rdata     (arr_rdata),
        .parity_err(arr_perr)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pattern_d    = pattern_q;
        err_count_d  = err_count_q;
        fail_addr_d  = fail_addr_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        // Functional port owns the array only while the FSM is idle.
        arr_we       = write_enable && (state_q == IDLE);
        arr_re       = read_enable && (state_q == IDLE);
        arr_addr     = address;
        arr_wdata    = data_input;
        read_valid_d = arr_re;

        case (state_q)
            IDLE: begin
                if (bist_start) begin
                    state_d     = CLEAR;
                    addr_d      = '0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    err_count_d = '0;
                end
            end
            CLEAR: begin
                arr_we    = 1'b1;
                arr_addr  = addr_q;
                arr_wdata = PAT_ZEROS[DATA_WIDTH-1:0];
                if (addr_q == LAST_ADDR) begin
                    state_d   = WRITE;
                    addr_d    = '0;
                    pattern_d = PAT_ONES[DATA_WIDTH-1:0];
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            WRITE: begin
                arr_we    = 1'b1;
                arr_addr  = addr_q;
                arr_wdata = pattern_q;
                state_d   = READ;
            end
            READ: begin
                arr_re   = 1'b1;
                arr_addr = addr_q;
                state_d  = CHECK;
            end
            CHECK: begin
                if ((arr_rdata != pattern_q) || arr_perr) begin
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                    // A zero count means this is the first failing word.
                    if (err_count_q == '0) begin
                        fail_addr_d = addr_q;
                    end
                end
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    state_d   = WRITE;
                    addr_d    = addr_q + 1'b1;
                    pattern_d = ~pattern_q;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_count_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            pattern_q    <= '0;
            err_count_q  <= '0;
            fail_addr_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            read_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pattern_q    <= pattern_d;
            err_count_q  <= err_count_d;
            fail_addr_q  <= fail_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign data_output    = arr_rdata;
    assign read_valid     = read_valid_q;
    assign parity_err     = read_valid_q & arr_perr;
    assign bist_busy      = busy_q;
    assign bist_done      = done_q;
    assign bist_pass      = pass_q;
    assign bist_fail_addr = fail_addr_q;
    assign bist_err_count = err_count_q;

endmodule

// File: tb/tb_memory_bist.sv
// Self-checking bench for memory_bist (8-bit words, 16 entries); MEMORY_PARITY_EN selects parity expectations.
module tb_memory_bist;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int BIST_LAT = 4 * DEPTH + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_input = '0;
    logic          write_enable = 1'b0;
    logic          read_enable = 1'b0;
    logic [DW-1:0] data_output;
    logic          read_valid;
    logic          parity_err;
    logic          bist_start = 1'b0;
    logic          bist_busy;
    logic          bist_done;
    logic          bist_pass;
    logic [AW-1:0] bist_fail_addr;
    logic [AW:0]   bist_err_count;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];

`ifdef MEMORY_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    memory_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .data_input    (data_input),
        .write_enable  (write_enable),
        .read_enable   (read_enable),
        .data_output   (data_output),
        .read_valid    (read_valid),
        .parity_err    (parity_err),
        .bist_start    (bist_start),
        .bist_busy     (bist_busy),
        .bist_done     (bist_done),
        .bist_pass     (bist_pass),
        .bist_fail_addr(bist_fail_addr),
        .bist_err_count(bist_err_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        address = a; data_input = d; write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic exp_perr);
        exp_q.push_back(model_mem[a]);
        @(negedge clk);
        address = a; read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
        check({tag, "_valid"}, 32'(read_valid), 32'd1);
        if (exp_q.size() != 0) check({tag, "_data"}, 32'(data_output), 32'(exp_q.pop_front()));
        check({tag, "_perr"}, 32'(parity_err), 32'(exp_perr));
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(read_valid), 32'd0);
    endtask

    task automatic do_write_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back(model_mem[a]);
        @(negedge clk);
        address = a; data_input = d; write_enable = 1'b1; read_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0; read_enable = 1'b0;
        model_mem[a] = d;
        check("wr_rd_valid", 32'(read_valid), 32'd1);
        if (exp_q.size() != 0) check("wr_rd_old_data", 32'(data_output), 32'(exp_q.pop_front()));
    endtask

    // Runs a BIST; optionally holds bit 0 of word 6 at 0 and aborts with reset after abort_at cycles.
    task automatic run_bist(input string tag, input bit stuck6, input int abort_at, output int lat);
        int n;
        bit rv_seen;
        @(negedge clk);
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        check({tag, "_busy_start"}, 32'(bist_busy), 32'd1);
        address = 4'd1; data_input = 8'h55; write_enable = 1'b1; read_enable = 1'b1;
        n = 0;
        rv_seen = 1'b0;
        while (!bist_done && n < 200) begin
            if (abort_at > 0 && n == abort_at) begin
                reset = 1'b0;
                break;
            end
            @(negedge clk);
            n++;
            if (stuck6) dut.u_array.mem_q[6][0] = 1'b0;
            if (read_valid) rv_seen = 1'b1;
        end
        write_enable = 1'b0; read_enable = 1'b0;
        check({tag, "_no_func_valid"}, 32'(rv_seen), 32'd0);
        if (abort_at == 0 && n >= 200) check({tag, "_timeout"}, 32'(n), 32'(BIST_LAT));
        lat = n;
    endtask

    int lat;
    logic [DW-1:0] pat;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_read_valid", 32'(read_valid), 32'd0);
        check("rst_data", 32'(data_output), 32'd0);
        check("rst_busy", 32'(bist_busy), 32'd0);
        check("rst_done", 32'(bist_done), 32'd0);
        check("rst_pass", 32'(bist_pass), 32'd0);
        check("rst_err_count", 32'(bist_err_count), 32'd0);
        reset = 1'b1;

        do_write(4'd3, 8'hA5);
        do_read("rd3", 4'd3, 1'b0);

        do_write(4'd5, 8'h11);
        do_write_read(4'd5, 8'h3C);
        do_read("rd5_new", 4'd5, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(8, 15));
            do_write(a, DW'($urandom_range(0, 255)));
            do_read("rand", a, 1'b0);
        end

        // fault-free BIST
        run_bist("bist1", 1'b0, 0, lat);
        check("bist1_latency", 32'(lat), 32'(BIST_LAT));
        check("bist1_pass", 32'(bist_pass), 32'd1);
        check("bist1_err_count", 32'(bist_err_count), 32'd0);
        check("bist1_busy_at_done", 32'(bist_busy), 32'd0);
        @(negedge clk);
        check("bist1_done_pulse", 32'(bist_done), 32'd0);
        pat = '1;
        for (int a = 0; a < DEPTH; a++) begin
            model_mem[a] = pat;
            pat = ~pat;
        end
        do_read("post_bist0", 4'd0, 1'b0);
        do_read("post_bist1", 4'd1, 1'b0);
        do_read("post_bist14", 4'd14, 1'b0);
        do_read("post_bist15", 4'd15, 1'b0);

        // stuck-at-0 on bit 0 of word 6
        run_bist("bist2", 1'b1, 0, lat);
        check("bist2_latency", 32'(lat), 32'(BIST_LAT));
        check("bist2_pass", 32'(bist_pass), 32'd0);
        check("bist2_fail_addr", 32'(bist_fail_addr), 32'd6);
        check("bist2_err_count", 32'(bist_err_count), 32'd1);
        repeat (3) @(negedge clk);
        check("bist2_hold_fail_addr", 32'(bist_fail_addr), 32'd6);
        check("bist2_hold_err_count", 32'(bist_err_count), 32'd1);
        dut.u_array.mem_q[6][0] = 1'b1;

        // reset in the middle of a BIST
        run_bist("bist3", 1'b0, 20, lat);
        @(negedge clk);
        check("abort_busy", 32'(bist_busy), 32'd0);
        check("abort_done", 32'(bist_done), 32'd0);
        check("abort_pass", 32'(bist_pass), 32'd0);
        check("abort_fail_addr", 32'(bist_fail_addr), 32'd0);
        check("abort_err_count", 32'(bist_err_count), 32'd0);
        check("abort_read_valid", 32'(read_valid), 32'd0);
        check("abort_data", 32'(data_output), 32'd0);
        reset = 1'b1;
        run_bist("bist4", 1'b0, 0, lat);
        check("bist4_latency", 32'(lat), 32'(BIST_LAT));
        check("bist4_pass", 32'(bist_pass), 32'd1);

        // single stored data bit flipped in word 2
        dut.u_array.mem_q[2][0] = ~dut.u_array.mem_q[2][0];
        model_mem[2] = model_mem[2] ^ 8'h01;
        do_read("parity2", 4'd2, PAR_ON);
        do_read("parity3", 4'd3, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
